// File: rtl/ahb_slave_interface.sv
// AHB slave front end of the AHB-to-APB bridge.
// Decodes the APB peripheral and qualifies transfers. Address, write data and
// direction are delayed through a two-stage pipeline. Hreadyout/Hresp carry
// the AHB response.
// Optional feature macro: AHB_SLV_ERR_RESP_EN. When it is defined, unmapped
// transfers get a two-cycle ERROR response. When it is undefined, they are
// silently dropped.
module ahb_slave_interface #(
  parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
  parameter logic [31:0] REGION_MASK = 32'hFC00_0000
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic        apb_ready,
  input  logic [31:0] Prdata,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic        Hwritereg1,
  output logic [2:0]  tempselx,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic        xfer;
  logic        mapped;
  logic        addr_ok;  // the current cycle is a legal address-phase sample point

  logic [31:0] haddr1_q, haddr1_d, haddr2_q, haddr2_d;
  logic [31:0] hwdata1_q, hwdata1_d, hwdata2_q, hwdata2_d;
  logic        hwrite1_q, hwrite1_d, hwrite2_q, hwrite2_d;

  // Region decode of the current address into a one-hot peripheral select
  always_comb begin
    tempselx = 3'b000;
    if ((Haddr & REGION_MASK) == SLV0_BASE)      tempselx = 3'b001;
    else if ((Haddr & REGION_MASK) == SLV1_BASE) tempselx = 3'b010;
    else if ((Haddr & REGION_MASK) == SLV2_BASE) tempselx = 3'b100;
  end

  assign mapped = |tempselx;
  assign xfer   = (Htrans == TR_NONSEQ) || (Htrans == TR_SEQ);
  assign valid  = !Hreset && Hreadyin && xfer && mapped && addr_ok;
  assign Hrdata = Prdata;

  // Pipeline advances only on accepted cycles and holds while Hreadyin is low
  always_comb begin
    haddr1_d  = haddr1_q;
    haddr2_d  = haddr2_q;
    hwdata1_d = hwdata1_q;
    hwdata2_d = hwdata2_q;
    hwrite1_d = hwrite1_q;
    hwrite2_d = hwrite2_q;
    if (Hreadyin) begin
      haddr1_d  = Haddr;
      haddr2_d  = haddr1_q;
      hwdata1_d = Hwdata;
      hwdata2_d = hwdata1_q;
      hwrite1_d = Hwrite;
      hwrite2_d = hwrite1_q;
    end
  end

  // Pipeline registers with synchronous clear
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite1_q <= 1'b0;
      hwrite2_q <= 1'b0;
    end else begin
      haddr1_q  <= haddr1_d;
      haddr2_q  <= haddr2_d;
      hwdata1_q <= hwdata1_d;
      hwdata2_q <= hwdata2_d;
      hwrite1_q <= hwrite1_d;
      hwrite2_q <= hwrite2_d;
    end
  end

  assign Haddr1     = haddr1_q;
  assign Haddr2     = haddr2_q;
  assign Hwdata1    = hwdata1_q;
  assign Hwdata2    = hwdata2_q;
  assign Hwritereg  = hwrite1_q;
  assign Hwritereg1 = hwrite2_q;

`ifdef AHB_SLV_ERR_RESP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_e;
  state_e state_q, state_d;
  logic   bad_xfer;

  assign bad_xfer = Hreadyin && Htrans[1] && !mapped;

  // Error FSM state register
  always_ff @(posedge Hclk) begin
    if (Hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: an unmapped transfer starts the two-cycle ERROR response,
  // and a back-to-back unmapped transfer sampled in ERR2 restarts it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bad_xfer) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = bad_xfer ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response outputs decoded from state
  always_comb begin
    Hreadyout = apb_ready;
    Hresp     = 2'b00;
    addr_ok   = 1'b1;
    case (state_q)
      ST_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = 2'b01;
        addr_ok   = 1'b0;
      end
      ST_ERR2: begin
        Hreadyout = 1'b1;
        Hresp     = 2'b01;
      end
      default: ;
    endcase
  end
`else
  // With no error response, unmapped transfers are just never qualified
  always_comb begin
    Hreadyout = apb_ready;
    Hresp     = 2'b00;
    addr_ok   = 1'b1;
  end
`endif

endmodule

// File: doc/ahb_slave_interface.md
Name: ahb_slave_interface

Overview:
- AHB-side front end of the AHB-to-APB bridge; sits directly downstream of the AHB master and feeds the APB controller FSM.
- Qualifies AHB transfers, decodes the target APB peripheral, and pipelines address, write data and direction by two stages to align with the APB setup/access phases.
- Generates the AHB response (Hreadyout, Hresp, Hrdata), including a two-cycle ERROR response for unmapped addresses.

Parameters:
- SLV0_BASE, 32'h8000_0000, base address of APB peripheral 0
- SLV1_BASE, 32'h8400_0000, base address of APB peripheral 1
- SLV2_BASE, 32'h8800_0000, base address of APB peripheral 2
- REGION_MASK, 32'hFC00_0000, mask applied to Haddr before comparing with a base (64 MB regions)

Ports:
- Hclk  in  1  bridge clock; all state updates on the rising edge
- Hreset  in  1  synchronous, active-high reset
- Haddr  in  32  AHB address
- Hwdata  in  32  AHB write data, valid one cycle after its address phase
- Hwrite  in  1  1 = write, 0 = read
- Hreadyin  in  1  system HREADY
- Htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- apb_ready  in  1  APB controller can accept or has completed a transfer
- Prdata  in  32  APB read data
- valid  out  1  qualified mapped transfer in the current address phase
- Haddr1, Haddr2  out  32  address delayed by 1 and 2 accepted cycles
- Hwdata1, Hwdata2  out  32  write data delayed by 1 and 2 accepted cycles
- Hwritereg, Hwritereg1  out  1  Hwrite delayed by 1 and 2 accepted cycles
- tempselx  out  3  one-hot peripheral select; 000 when unmapped
- Hreadyout  out  1  AHB ready response
- Hresp  out  2  00 OKAY, 01 ERROR
- Hrdata  out  32  AHB read data

Behaviour:
- Reset: when Hreset=1 at a clock edge, all pipeline registers go to 0 and the FSM enters IDLE.
  - Reset is synchronous and active-high: the change takes effect at that edge.
  - After reset, with apb_ready=1: valid=0, Hreadyout=1, Hresp=00.
  - Reset mid-burst aborts the burst: the pipeline clears and no error is held.
- Decode (combinational):
  - tempselx=001 if (Haddr&REGION_MASK)==SLV0_BASE; 010 for SLV1_BASE; 100 for SLV2_BASE; otherwise 000.
  - mapped = |tempselx.
- valid (combinational): 1 only when all of the following hold:
  - Hreset=0
  - Hreadyin=1
  - Htrans is NONSEQ or SEQ
  - mapped=1
  - FSM is in IDLE or ERR2
  - IDLE and BUSY transfers never assert valid.
- Pipeline, per edge with Hreadyin=1:
  - Haddr1<=Haddr, Haddr2<=Haddr1.
  - Hwdata1<=Hwdata, Hwdata2<=Hwdata1.
  - Hwritereg<=Hwrite, Hwritereg1<=Hwritereg.
  - With Hreadyin=0 all pipeline registers hold.
  - Latency: address to Haddr1 is 1 cycle; Hwdata to Hwdata1 is 1 cycle after the data phase.
- Error FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 when Hreadyin=1, Htrans[1]=1 and mapped=0.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 if another unmapped NONSEQ/SEQ is sampled; otherwise ERR2 -> IDLE.
  - Address phases presented during ERR1 are ignored (Hreadyout=0).
  - The ERR2 cycle is a legal address-phase sample point.
- Response:
  - IDLE: Hreadyout=apb_ready, Hresp=00.
  - ERR1: Hreadyout=0, Hresp=01.
  - ERR2: Hreadyout=1, Hresp=01.
  - Hrdata=Prdata, combinational passthrough.
- Simultaneous events:
  - Unmapped and mapped transfers are mutually exclusive per cycle.
  - A mapped transfer sampled in ERR2 asserts valid and moves the FSM to IDLE.

Optional Feature:
- Macro: AHB_SLV_ERR_RESP_EN.
- Defined: the error FSM and ERROR response above are present.
- Undefined: no FSM. An unmapped transfer is silently dropped: valid=0, Hresp is constantly 00, and Hreadyout=apb_ready. The pipeline still captures the address.

Test Plan:
- Single write: Haddr=0x8000_0001, Hwrite=1, Htrans=2, Hreadyin=1; Hwdata=0x80 next cycle.
  - valid=1 and tempselx=001 in the address cycle.
  - After 1 edge: Haddr1=0x8000_0001, Hwritereg=1.
  - After 2 edges: Hwdata1=0x80, Haddr2=0x8000_0001.
- Single read: Haddr=0x8000_0001, Hwrite=0, Prdata=0xA5.
  - valid=1 and Hwritereg=0 one edge later.
  - Hrdata=0xA5; Hresp=00.
- Burst write: NONSEQ 0x8000_0001 followed by SEQ 0x8000_0002..0x8000_0004, then IDLE.
  - valid=1 for 4 consecutive cycles, then 0.
  - Haddr2 trails Haddr by 2 edges.
  - Hwdata2 matches each beat's data, 2 edges after its data phase.
- Hold: Hreadyin=0 for 2 cycles mid-burst.
  - Haddr1/Haddr2/Hwdata1/Hwdata2 are unchanged; valid=0.
  - apb_ready=0 gives Hreadyout=0.
- Unmapped: NONSEQ to 0x9000_0000.
  - valid=0, tempselx=000.
  - Next cycle Hresp=01, Hreadyout=0; following cycle Hresp=01, Hreadyout=1; then Hresp=00.
  - With the macro undefined: Hresp stays 00.
- Reset mid-burst: assert Hreset for 1 edge during the beat at 0x8000_0002.
  - After that edge, all pipeline outputs=0 and valid=0.
  - Hreadyout=apb_ready; FSM in IDLE.
